// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: raster position, sync strobes and pixel/frame
// qualifiers produced by the timing generator and consumed by the
// pixel pipeline.
interface vga_timing_gen_if;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       frame_start;

    modport master (
        output pix_tick,
        output hsync,
        output vsync,
        output video_on,
        output pix_x,
        output pix_y,
        output frame_start
    );

    modport slave (
        input pix_tick,
        input hsync,
        input vsync,
        input video_on,
        input pix_x,
        input pix_y,
        input frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A clk/2 pixel enable drives a horizontal
// and a vertical counter; all decoded outputs are registered from the
// next-state counter values so they move on the same edge as pix_x/pix_y.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       pix_tick_r;
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       video_on_r;
    logic       frame_start_r;

    logic       advance_s;
    logic       frame_wrap_s;
    logic [9:0] h_nxt_s;
    logic [9:0] v_nxt_s;
    logic       hsync_s;
    logic       vsync_s;
    logic       video_on_s;

    // Next raster position and the decodes derived from it.
    always_comb begin
        advance_s    = en & pix_tick_r;
        h_nxt_s      = h_cnt_r;
        v_nxt_s      = v_cnt_r;
        frame_wrap_s = 1'b0;
        if (advance_s) begin
            if (h_cnt_r == H_MAX) begin
                h_nxt_s = 10'd0;
                if (v_cnt_r == V_MAX) begin
                    v_nxt_s      = 10'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    v_nxt_s = v_cnt_r + 10'd1;
                end
            end else begin
                h_nxt_s = h_cnt_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r;
        end

        video_on_s = (h_nxt_s < H_ACT_END) && (v_nxt_s < V_ACT_END);
        if ((h_nxt_s >= HS_START) && (h_nxt_s < HS_END)) begin
            hsync_s = SYNC_POL;
        end else begin
            hsync_s = ~SYNC_POL;
        end
        if ((v_nxt_s >= VS_START) && (v_nxt_s < VS_END)) begin
            vsync_s = SYNC_POL;
        end else begin
            vsync_s = ~SYNC_POL;
        end
    end

    // Timing state and registered outputs; everything freezes while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_tick_r    <= 1'b0;
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (en) begin
            pix_tick_r    <= ~pix_tick_r;
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            video_on_r    <= video_on_s;
            frame_start_r <= frame_wrap_s;
        end else begin
            frame_start_r <= 1'b0;
        end
    end

    assign vga.pix_tick    = pix_tick_r;
    assign vga.pix_x       = h_cnt_r;
    assign vga.pix_y       = v_cnt_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.video_on    = video_on_r;
    assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a tiny raster
// for whole-frame checks, default timing with positive sync) are compared
// every cycle against a closed-form model driven by the count of enabled
// clock edges since reset, plus hand-computed literal checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       tick;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;
    logic run_chk = 1'b0;

    longint e_cnt   = 0;
    logic   last_en = 1'b0;
    logic   prev_fs_a = 1'b0;
    logic   prev_fs_b = 1'b0;
    logic   prev_fs_c = 1'b0;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();
    vga_timing_gen_if ifc ();

    vga_timing_gen dut_a (.clk(clk), .rst_n(rst_n), .en(en), .vga(ifa));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .en(en), .vga(ifb));

    vga_timing_gen #(.SYNC_POL(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .en(en), .vga(ifc));

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after e enabled edges since reset release.
    function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input logic pol, input longint e, input logic le);
        exp_t   r;
        longint ht, vt, a;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (e == 0) begin
            r = '{tick: 1'b0, hs: ~pol, vs: ~pol, vid: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0};
        end else begin
            a      = e / 2;
            r.tick = ((e % 2) == 1);
            r.x    = 10'(a % ht);
            r.y    = 10'((a / ht) % vt);
            r.vid  = (r.x < ha) && (r.y < va);
            r.hs   = ((r.x >= ha + hf) && (r.x < ha + hf + hsw)) ? pol : ~pol;
            r.vs   = ((r.y >= va + vf) && (r.y < va + vf + vsw)) ? pol : ~pol;
            r.fs   = le && ((e % 2) == 0) && ((a % (ht * vt)) == 0);
        end
        return r;
    endfunction

    task automatic cmp(input string tag, input exp_t x, input int ht, input int vt,
                       input logic tk, input logic hs, input logic vs, input logic vid,
                       input logic fs, input logic [9:0] px, input logic [9:0] py,
                       input logic pfs);
        check({tag, ".pix_tick"},    tk,  x.tick);
        check({tag, ".hsync"},       hs,  x.hs);
        check({tag, ".vsync"},       vs,  x.vs);
        check({tag, ".video_on"},    vid, x.vid);
        check({tag, ".frame_start"}, fs,  x.fs);
        check({tag, ".pix_x"},       px,  x.x);
        check({tag, ".pix_y"},       py,  x.y);
        check({tag, ".x_in_range"},  (px < ht), 1);
        check({tag, ".y_in_range"},  (py < vt), 1);
        check({tag, ".fs_single"},   (pfs && fs), 0);
    endtask

    // Reference: count of enabled edges since reset and whether the last edge was enabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt   <= 0;
            last_en <= 1'b0;
        end else if (en) begin
            e_cnt   <= e_cnt + 1;
            last_en <= 1'b1;
        end else begin
            last_en <= 1'b0;
        end
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            cmp("A", model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, e_cnt, last_en), 800, 525,
                ifa.pix_tick, ifa.hsync, ifa.vsync, ifa.video_on, ifa.frame_start,
                ifa.pix_x, ifa.pix_y, prev_fs_a);
            cmp("B", model(8, 2, 3, 2, 6, 1, 2, 2, 1'b0, e_cnt, last_en), 15, 11,
                ifb.pix_tick, ifb.hsync, ifb.vsync, ifb.video_on, ifb.frame_start,
                ifb.pix_x, ifb.pix_y, prev_fs_b);
            cmp("C", model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, e_cnt, last_en), 800, 525,
                ifc.pix_tick, ifc.hsync, ifc.vsync, ifc.video_on, ifc.frame_start,
                ifc.pix_x, ifc.pix_y, prev_fs_c);
            prev_fs_a <= ifa.frame_start;
            prev_fs_b <= ifb.frame_start;
            prev_fs_c <= ifc.frame_start;
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        int vid_cnt, hs_lo_cnt, hs_first_x, c_hs_hi_cnt, c_first_x;
        int k, hold, vs_lo_cnt, vid_bad;
        logic found;
        logic [9:0] held_x;
        logic held_tk, held_hs, held_vid;

        #1 rst_n = 1'b0;
        #1 run_chk = 1'b1;
        #1;
        check("rst.pix_tick", ifa.pix_tick, 0);
        check("rst.pix_x", ifa.pix_x, 0);
        check("rst.hsync", ifa.hsync, 1);
        check("rst.vsync", ifa.vsync, 1);
        check("rst.video_on", ifa.video_on, 0);
        check("rst.c_hsync", ifc.hsync, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // One line plus one pixel of the default raster.
        vid_cnt = 0; hs_lo_cnt = 0; hs_first_x = -1; c_hs_hi_cnt = 0; c_first_x = -1;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("first.pix_tick", ifa.pix_tick, 1);
                check("first.video_on", ifa.video_on, 1);
                check("first.pix_x", ifa.pix_x, 0);
                check("first.frame_start", ifa.frame_start, 0);
            end
            if (i == 1599) check("line.last_x", ifa.pix_x, 799);
            if (ifa.video_on) vid_cnt++;
            if (!ifa.hsync) begin
                if (hs_first_x < 0) hs_first_x = int'(ifa.pix_x);
                hs_lo_cnt++;
            end
            if (ifc.hsync) begin
                if (c_first_x < 0) c_first_x = int'(ifc.pix_x);
                c_hs_hi_cnt++;
            end
        end
        check("line.video_clks", vid_cnt, 1280);
        check("line.hsync_low_clks", hs_lo_cnt, 192);
        check("line.hsync_first_x", hs_first_x, 656);
        check("pol1.hsync_high_clks", c_hs_hi_cnt, 192);
        check("pol1.hsync_first_x", c_first_x, 656);

        // Pause at pix_x=300.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (ifa.pix_x == 10'd300) found = 1'b1;
        end
        check("wait.x300", found, 1);
        held_x = ifa.pix_x; held_tk = ifa.pix_tick; held_hs = ifa.hsync; held_vid = ifa.video_on;
        en = 1'b0;
        repeat (37) @(negedge clk);
        check("pause.pix_x", ifa.pix_x, 300);
        check("pause.pix_tick", ifa.pix_tick, held_tk);
        check("pause.hsync", ifa.hsync, held_hs);
        check("pause.video_on", ifa.video_on, held_vid);
        check("pause.frame_start", ifa.frame_start, 0);
        en = 1'b1;
        k = 0;
        while (ifa.pix_x == held_x && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("resume.next_x", ifa.pix_x, 301);
        hold = 0;
        while (ifa.pix_x == 10'd301 && hold < 10) begin
            @(negedge clk);
            hold++;
        end
        check("resume.hold_clks", hold, 2);
        check("resume.after_x", ifa.pix_x, 302);

        // Whole frame of the small raster: 15 x 11 pixels, 2 clks each.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (ifb.frame_start) found = 1'b1;
        end
        check("wait.b_frame", found, 1);
        k = 0; vs_lo_cnt = 0; vid_bad = 0; found = 1'b0;
        while (!found && k < 400) begin
            @(negedge clk);
            k++;
            if (!ifb.vsync) vs_lo_cnt++;
            if (ifb.video_on && ifb.pix_y >= 10'd6) vid_bad++;
            if (ifb.frame_start) found = 1'b1;
        end
        check("frame.period_clks", k, 330);
        check("frame.vsync_low_clks", vs_lo_cnt, 60);
        check("frame.video_below_active", vid_bad, 0);

        // Reset during the last vsync line.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (ifb.pix_y == 10'd8 && !ifb.vsync) found = 1'b1;
        end
        check("wait.b_vsync", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.vsync", ifb.vsync, 1);
        check("midrst.pix_x", ifb.pix_x, 0);
        check("midrst.pix_y", ifb.pix_y, 0);
        check("midrst.a_pix_x", ifa.pix_x, 0);
        check("midrst.a_pix_tick", ifa.pix_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0; found = 1'b0;
        while (!found && k < 400) begin
            @(negedge clk);
            k++;
            if (ifb.frame_start) found = 1'b1;
        end
        check("midrst.frame_clks", k, 330);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
